ddr_addr_gen_nd: RTL and testbench

//  N-dimensional (1..3 level nested-loop) DDR read/write command address generator.

---
 rtl/ddr_addr_gen_pkg.sv | 10 +
 rtl/ddr_addr_gen_nd_level.sv | 40 ++++
 rtl/ddr_addr_gen_nd.sv | 138 +++++++++++++
 tb/tb_ddr_addr_gen_nd.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ddr_addr_gen_pkg.sv
// Shared types and limits for the N-dimensional DDR command address generator.
package ddr_addr_gen_pkg;
  localparam int DIMS_MAX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2
  } state_t;
endpackage

// File: rtl/ddr_addr_gen_nd_level.sv
// One nested-loop level: iteration index plus the address at idx==0 of this level.
module addr_loop_level #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              carry_in,
  input  logic              reload,
  input  logic [ADDR_W-1:0] reload_base,
  input  logic [ADDR_W-1:0] step,
  input  logic [CNT_W-1:0]  cnt,
  output logic              wrap,
  output logic [ADDR_W-1:0] base
);
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt_last;

  assign cnt_last = cnt - CNT_W'(1);
  assign wrap     = (idx == cnt_last);

  // carry_in and reload are mutually exclusive: a level either advances or rewinds
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      base <= '0;
    end else if (load) begin
      idx  <= '0;
      base <= load_base;
    end else if (carry_in) begin
      idx  <= idx + CNT_W'(1);
      base <= base + step;
    end else if (reload) begin
      idx  <= '0;
      base <= reload_base;
    end
  end
endmodule

// File: rtl/ddr_addr_gen_nd.sv
// Nested-loop (1..3 level) DDR command address generator with valid/ready output channel.
module ddr_addr_gen_nd
  import ddr_addr_gen_pkg::*;
#(
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 16,
  parameter int CNT_W      = 16,
  parameter int DIMS       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DDR_ADDR_W-1:0]      st_addr,
  input  logic [BURST_W-1:0]         burst,
  input  logic [DIMS*DDR_ADDR_W-1:0] step,
  input  logic [DIMS*CNT_W-1:0]      cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       done_pulse,
  output logic                       cfg_err,
  output logic [DDR_ADDR_W-1:0]      ddr_addr,
  output logic [BURST_W-1:0]         ddr_size,
  output logic                       ddr_addr_valid,
  input  logic                       ddr_addr_ready
);
  typedef logic [DDR_ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  state_t                  state;
  logic [DIMS-1:0][DDR_ADDR_W-1:0] step_q;
  logic [DIMS-1:0][CNT_W-1:0]      cnt_q;
  logic [DIMS-1:0]         wrap, inc, rl_en, cout;
  addr_t                   base   [DIMS];
  addr_t                   rl_val [DIMS];
  logic                    fire, last, any_zero, start_ok;

  assign fire     = ddr_addr_valid & ddr_addr_ready;
  assign start_ok = (state == IDLE) & start & ~any_zero;

  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < DIMS; k++)
      if (cnt[k*CNT_W +: CNT_W] == cnt_t'(0)) any_zero = 1'b1;
  end

  // Carry ripples upward through wrapped levels; the first non-wrapped level advances.
  always_comb begin
    logic  c;
    addr_t acc;
    c   = fire;
    inc = '0;
    cout = '0;
    for (int k = 0; k < DIMS; k++) begin
      inc[k]  = c & ~wrap[k];
      c       = c & wrap[k];
      cout[k] = c;
    end
    last  = c;
    rl_en = '0;
    for (int k = 0; k < DIMS; k++) rl_en[k] = cout[k] & ~last;
    // Each level reloads with the new base of the nearest advancing level above it
    acc = '0;
    for (int k = DIMS - 1; k >= 0; k--) begin
      rl_val[k] = acc;
      if (inc[k]) acc = base[k] + step_q[k];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIMS; g++) begin : g_lvl
      addr_loop_level #(.ADDR_W(DDR_ADDR_W), .CNT_W(CNT_W)) u_lvl (
        .clk        (clk),
        .rst        (rst),
        .load       (start_ok),
        .load_base  (st_addr),
        .carry_in   (inc[g]),
        .reload     (rl_en[g]),
        .reload_base(rl_val[g]),
        .step       (step_q[g]),
        .cnt        (cnt_q[g]),
        .wrap       (wrap[g]),
        .base       (base[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b1;
      done_pulse     <= 1'b0;
      cfg_err        <= 1'b0;
      ddr_addr_valid <= 1'b0;
      ddr_addr       <= '0;
      ddr_size       <= '0;
      step_q         <= '0;
      cnt_q          <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: if (start) begin
          step_q   <= step;
          cnt_q    <= cnt;
          ddr_size <= burst;
          cfg_err  <= any_zero;
          if (any_zero) begin
            state <= ERR;
          end else begin
            state          <= ISSUE;
            busy           <= 1'b1;
            done           <= 1'b0;
            ddr_addr_valid <= 1'b1;
            ddr_addr       <= st_addr;
          end
        end
        ISSUE: begin
          if (abort || last) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b1;
            done_pulse     <= 1'b1;
            ddr_addr_valid <= 1'b0;
          end else if (fire) begin
            ddr_addr <= inc[0] ? ddr_addr + step_q[0] : rl_val[0];
          end
        end
        ERR: begin
          state      <= IDLE;
          done_pulse <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_addr_gen_nd.sv
// Directed bench for ddr_addr_gen_nd: sequences, backpressure, cfg error, abort, wrap, reset.
module tb_ddr_addr_gen_nd;
  logic        clk = 1'b0;
  logic        rst, start, abort, ready;
  logic [31:0] st_addr;
  logic [15:0] burst;
  logic [95:0] step;
  logic [47:0] cnt;
  logic        busy, done, done_pulse, cfg_err, valid;
  logic [31:0] ddr_addr;
  logic [15:0] ddr_size;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_a [0:7];

  ddr_addr_gen_nd #(.DDR_ADDR_W(32), .BURST_W(16), .CNT_W(16), .DIMS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .st_addr(st_addr), .burst(burst),
    .step(step), .cnt(cnt), .busy(busy), .done(done), .done_pulse(done_pulse),
    .cfg_err(cfg_err), .ddr_addr(ddr_addr), .ddr_size(ddr_size),
    .ddr_addr_valid(valid), .ddr_addr_ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] st, input logic [15:0] b,
                    input logic [31:0] s0, s1, s2, input logic [15:0] c0, c1, c2);
    st_addr = st; burst = b; step = {s2, s1, s0}; cnt = {c2, c1, c0};
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_end();
    chk("end_valid", {31'd0, valid}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_pulse", {31'd0, done_pulse}, 32'd1);
    tick();
    chk("pulse_clr", {31'd0, done_pulse}, 32'd0);
    chk("stay_idle", {31'd0, valid}, 32'd0);
  endtask

  // Drain n commands (or abort after stop_at), checking order, size and hold under backpressure.
  task automatic issue(input int n, input bit rnd, input int stop_at, input bit inj,
                       input logic [15:0] b);
    int got = 0;
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] pa = '0;
    logic [15:0] ps = '0;
    chk("first_valid", {31'd0, valid}, 32'd1);
    chk("first_busy", {31'd0, busy}, 32'd1);
    while (got < n && cyc < 200) begin
      if (stop_at != 0 && got == stop_at) break;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = inj && (cyc == 1);
      if (start) begin st_addr = 32'hDEAD_0000; cnt = '0; end
      if (pv && !pr) begin
        chk("hold_addr", ddr_addr, pa);
        chk("hold_size", {16'd0, ddr_size}, {16'd0, ps});
      end
      if (valid && ready) begin
        chk($sformatf("addr%0d", got), ddr_addr, exp_a[got]);
        chk("size", {16'd0, ddr_size}, {16'd0, b});
        got++;
      end
      pv = valid; pr = ready; pa = ddr_addr; ps = ddr_size;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("cmd_count", got, (stop_at != 0) ? stop_at : n);
    if (stop_at != 0) begin
      abort = 1'b1; ready = 1'b0;
      tick();
      abort = 1'b0;
    end
    ready = 1'b0;
    check_end();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    st_addr = '0; burst = '0; step = '0; cnt = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_pulse", {31'd0, done_pulse}, 32'd0);
    chk("rst_cfg", {31'd0, cfg_err}, 32'd0);
    chk("rst_addr", ddr_addr, 32'd0);
    chk("rst_size", {16'd0, ddr_size}, 32'd0);
    rst = 1'b0;
    tick();

    // 1-D stride, ready high
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1040; exp_a[2] = 32'h1080; exp_a[3] = 32'h10C0;
    go(32'h1000, 16'h0010, 32'h40, 32'h0, 32'h0, 16'd4, 16'd1, 16'd1);
    chk("c1_first_addr", ddr_addr, 32'h1000);
    issue(4, 1'b0, 0, 1'b0, 16'h0010);

    // 3-D 2x2x2, ready high then random backpressure
    exp_a[0] = 32'h0000; exp_a[1] = 32'h0010; exp_a[2] = 32'h0100; exp_a[3] = 32'h0110;
    exp_a[4] = 32'h1000; exp_a[5] = 32'h1010; exp_a[6] = 32'h1100; exp_a[7] = 32'h1110;
    go(32'h0, 16'h0020, 32'h10, 32'h100, 32'h1000, 16'd2, 16'd2, 16'd2);
    issue(8, 1'b0, 0, 1'b0, 16'h0020);
    go(32'h0, 16'h0030, 32'h10, 32'h100, 32'h1000, 16'd2, 16'd2, 16'd2);
    issue(8, 1'b1, 0, 1'b0, 16'h0030);

    // zero count -> config error, no commands
    go(32'h0, 16'h0040, 32'h10, 32'h100, 32'h1000, 16'd2, 16'd0, 16'd2);
    chk("err_valid1", {31'd0, valid}, 32'd0);
    chk("err_busy1", {31'd0, busy}, 32'd0);
    chk("err_cfg1", {31'd0, cfg_err}, 32'd1);
    chk("err_pulse_t1", {31'd0, done_pulse}, 32'd0);
    tick();
    chk("err_pulse_t2", {31'd0, done_pulse}, 32'd1);
    chk("err_valid2", {31'd0, valid}, 32'd0);
    chk("err_busy2", {31'd0, busy}, 32'd0);
    tick();
    chk("err_pulse_clr", {31'd0, done_pulse}, 32'd0);
    chk("err_sticky", {31'd0, cfg_err}, 32'd1);

    // abort after 3 commands; start while busy must not relatch
    go(32'h0, 16'h0050, 32'h10, 32'h100, 32'h1000, 16'd2, 16'd2, 16'd2);
    chk("cfg_cleared", {31'd0, cfg_err}, 32'd0);
    issue(8, 1'b0, 3, 1'b1, 16'h0050);

    // address wrap; start with abort together in idle is accepted
    exp_a[0] = 32'hFFFF_FFF0; exp_a[1] = 32'h0000_0010; exp_a[2] = 32'h0000_0030;
    abort = 1'b1;
    go(32'hFFFF_FFF0, 16'h0060, 32'h20, 32'h0, 32'h0, 16'd3, 16'd1, 16'd1);
    abort = 1'b0;
    issue(3, 1'b0, 0, 1'b0, 16'h0060);

    // reset mid-run
    go(32'hFFFF_FFF0, 16'h0070, 32'h20, 32'h0, 32'h0, 16'd3, 16'd1, 16'd1);
    ready = 1'b1;
    tick();
    chk("mid_addr", ddr_addr, 32'h0000_0010);
    rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0;
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_pulse", {31'd0, done_pulse}, 32'd0);
    tick();
    chk("mrst_pulse2", {31'd0, done_pulse}, 32'd0);
    chk("mrst_valid2", {31'd0, valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
